// File: rtl/mul_error_evaluator_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_error_evaluator_if
// Description : Bundles the run control, the operand/product link to the
//               multiplier under test, and the result bus of the
//               approximate-multiplier error evaluator.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   start        run request (into evaluator)
//   a_op, b_op   4-bit operands driven to the multiplier under test
//   approx_in    8-bit product returned by the multiplier under test
//   busy, done   sweep status
//   err_count    pairs with approx != exact
//   sum_err_dist sum of |approx - exact|
//   max_err_dist largest |approx - exact|
//   sum_rel_err  sum of Q8.8 relative errors (exact != 0 only)
// Modports:
//   master : evaluator side
//   slave  : environment side (run controller + multiplier under test)
// ============================================================================
interface mul_error_evaluator_if;
   logic        start;
   logic [3:0]  a_op;
   logic [3:0]  b_op;
   logic [7:0]  approx_in;
   logic        busy;
   logic        done;
   logic [8:0]  err_count;
   logic [15:0] sum_err_dist;
   logic [7:0]  max_err_dist;
   logic [23:0] sum_rel_err;

   modport master (
      input  start, approx_in,
      output a_op, b_op, busy, done,
             err_count, sum_err_dist, max_err_dist, sum_rel_err
   );

   modport slave (
      output start, approx_in,
      input  a_op, b_op, busy, done,
             err_count, sum_err_dist, max_err_dist, sum_rel_err
   );
endinterface
`default_nettype wire

// File: rtl/mul_error_evaluator.sv
`default_nettype none
// ============================================================================
// Module      : mul_error_evaluator
// Description : Sweeps all 256 operand pairs of a 4x4 combinational
//               multiplier under test, compares each returned product with
//               the exact product and accumulates error statistics. The
//               relative error (d<<8)/exact is formed by a 16-cycle
//               restoring divider.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk    in   rising-edge system clock
//   rst_n  in   asynchronous active-low reset
//   bus    master modport of mul_error_evaluator_if (start, operands,
//               returned product, status and result counters)
// ============================================================================
module mul_error_evaluator (
   input  wire logic             clk,
   input  wire logic             rst_n,
   mul_error_evaluator_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DRIVE   = 3'd1,
      S_CAPTURE = 3'd2,
      S_DIVIDE  = 3'd3,
      S_ACCUM   = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   localparam logic [7:0] C_LAST_IDX  = 8'hFF;
   localparam logic [3:0] C_LAST_STEP = 4'd15;

   state_t      state_q;
   logic [7:0]  idx_q;
   logic [3:0]  a_op_q;
   logic [3:0]  b_op_q;
   logic [7:0]  exact_q;
   logic [7:0]  dist_q;
   logic [7:0]  rem_q;
   // Holds the dividend {d, 8'h00}; its MSB is shifted into the remainder each
   // step while quotient bits enter at the LSB, so after 16 steps it is rel.
   logic [15:0] quot_q;
   logic [3:0]  div_cnt_q;
   logic        busy_q;
   logic        done_q;
   logic [8:0]  err_count_q;
   logic [15:0] sum_err_q;
   logic [7:0]  max_err_q;
   logic [23:0] sum_rel_q;

   logic [7:0]  dist_d;
   logic [8:0]  rem_sh_d;
   logic        q_bit_d;
   logic [7:0]  rem_d;

   always_comb begin
      dist_d   = (bus.approx_in >= exact_q) ? (bus.approx_in - exact_q)
                                            : (exact_q - bus.approx_in);
      rem_sh_d = {rem_q, quot_q[15]};
      q_bit_d  = (rem_sh_d >= {1'b0, exact_q});
      // The remainder is always below the divisor, so an 8-bit subtract is
      // exact whenever the quotient bit is set.
      rem_d    = q_bit_d ? (rem_sh_d[7:0] - exact_q) : rem_sh_d[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= 8'h00;
         a_op_q      <= 4'h0;
         b_op_q      <= 4'h0;
         exact_q     <= 8'h00;
         dist_q      <= 8'h00;
         rem_q       <= 8'h00;
         quot_q      <= 16'h0000;
         div_cnt_q   <= 4'h0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_count_q <= 9'h000;
         sum_err_q   <= 16'h0000;
         max_err_q   <= 8'h00;
         sum_rel_q   <= 24'h000000;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  idx_q       <= 8'h00;
                  err_count_q <= 9'h000;
                  sum_err_q   <= 16'h0000;
                  max_err_q   <= 8'h00;
                  sum_rel_q   <= 24'h000000;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  state_q     <= S_DRIVE;
               end
            end

            S_DRIVE: begin
               a_op_q  <= idx_q[7:4];
               b_op_q  <= idx_q[3:0];
               exact_q <= {4'h0, idx_q[7:4]} * {4'h0, idx_q[3:0]};
               state_q <= S_CAPTURE;
            end

            S_CAPTURE: begin
               dist_q    <= dist_d;
               rem_q     <= 8'h00;
               div_cnt_q <= 4'h0;
               if (exact_q != 8'h00) begin
                  quot_q  <= {dist_d, 8'h00};
                  state_q <= S_DIVIDE;
               end else begin
                  quot_q  <= 16'h0000;
                  state_q <= S_ACCUM;
               end
            end

            S_DIVIDE: begin
               rem_q     <= rem_d;
               quot_q    <= {quot_q[14:0], q_bit_d};
               div_cnt_q <= div_cnt_q + 4'd1;
               if (div_cnt_q == C_LAST_STEP) begin
                  state_q <= S_ACCUM;
               end
            end

            S_ACCUM: begin
               sum_err_q   <= sum_err_q + {8'h00, dist_q};
               err_count_q <= err_count_q + {8'h00, (dist_q != 8'h00)};
               if (dist_q > max_err_q) begin
                  max_err_q <= dist_q;
               end
               if (exact_q != 8'h00) begin
                  sum_rel_q <= sum_rel_q + {8'h00, quot_q};
               end
               if (idx_q == C_LAST_IDX) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  idx_q   <= idx_q + 8'd1;
                  state_q <= S_DRIVE;
               end
            end

            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.a_op         = a_op_q;
   assign bus.b_op         = b_op_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.err_count    = err_count_q;
   assign bus.sum_err_dist = sum_err_q;
   assign bus.max_err_dist = max_err_q;
   assign bus.sum_rel_err  = sum_rel_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_error_evaluator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mul_error_evaluator
// Description : Self-checking bench for mul_error_evaluator. The multiplier
//               under test is modelled combinationally with selectable
//               behaviour (exact, zero, single +1 error, random table).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_error_evaluator;

   localparam int SWEEP_CYCLES = 4368;
   localparam int CYCLE_LIMIT  = 6000;

   typedef struct {
      int mode;
      int e_err;
      int e_sum;
      int e_max;
      int e_rel;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   int         checks = 0;
   int         errors = 0;
   int         mode   = 0;
   logic [7:0] approx_tbl [256];

   mul_error_evaluator_if bus();

   mul_error_evaluator dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Multiplier under test
   always_comb begin
      bus.approx_in = 8'h00;
      case (mode)
         0: bus.approx_in = 8'(bus.a_op) * 8'(bus.b_op);
         1: bus.approx_in = 8'h00;
         2: bus.approx_in = 8'(bus.a_op) * 8'(bus.b_op)
                            + 8'((bus.a_op == 4'd3) && (bus.b_op == 4'd5));
         default: bus.approx_in = approx_tbl[{bus.a_op, bus.b_op}];
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Reference: walk all 256 pairs with plain arithmetic
   function automatic vec_t model(input int m);
      vec_t r;
      r = '{m, 0, 0, 0, 0};
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            int ex, ap, d;
            ex = a * b;
            case (m)
               0: ap = ex;
               1: ap = 0;
               2: ap = ((a == 3) && (b == 5)) ? ex + 1 : ex;
               default: ap = int'(approx_tbl[a*16 + b]);
            endcase
            d = (ap > ex) ? ap - ex : ex - ap;
            if (d != 0) r.e_err++;
            r.e_sum += d;
            if (d > r.e_max) r.e_max = d;
            if (ex != 0) r.e_rel += (d * 256) / ex;
         end
      end
      return r;
   endfunction

   task automatic check_results(input string tag, input vec_t e);
      chk({tag, "_done"},      32'(bus.done),         32'd1);
      chk({tag, "_err_count"}, 32'(bus.err_count),    32'(e.e_err));
      chk({tag, "_sum_err"},   32'(bus.sum_err_dist), 32'(e.e_sum));
      chk({tag, "_max_err"},   32'(bus.max_err_dist), 32'(e.e_max));
      chk({tag, "_sum_rel"},   32'(bus.sum_rel_err),  32'(e.e_rel));
   endtask

   // Pulse start, count busy cycles (bounded), optionally re-pulse start
   // mid-run and record the operand sequence.
   task automatic run_sweep(input int repulse_at, input bit monitor, output int n);
      int         seen[$];
      int         holds[$];
      int         cur;
      logic [7:0] pair, last;
      int         bad;
      cur  = 0;
      last = 8'h00;
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      n = 0;
      while (bus.busy === 1'b1 && n < CYCLE_LIMIT) begin
         n++;
         if (monitor && n >= 2) begin
            pair = {bus.a_op, bus.b_op};
            if (n == 2 || pair != last) begin
               if (n > 2) holds.push_back(cur);
               seen.push_back(int'(pair));
               cur = 1;
            end else begin
               cur++;
            end
            last = pair;
         end
         @(negedge clk);
         bus.start = (n == repulse_at);
      end
      bus.start = 1'b0;
      if (monitor) begin
         holds.push_back(cur);
         chk("pair_count", 32'(seen.size()), 32'd256);
         if (seen.size() == 256 && holds.size() == 256) begin
            chk("pair_first", 32'(seen[0]),   32'h00);
            chk("pair_17",    32'(seen[17]),  32'h11);
            chk("pair_last",  32'(seen[255]), 32'hFF);
            bad = 0;
            for (int k = 0; k < 256; k++) begin
               int exp_hold;
               exp_hold = ((k / 16) * (k % 16) == 0) ? 3 : 19;
               if (k == 255) exp_hold = 18;
               if (seen[k] != k || holds[k] != exp_hold) bad++;
            end
            chk("pair_hold_bad", 32'(bad), 32'd0);
         end
      end
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [3];
      vec_t e;
      int   cyc;

      bus.start = 1'b0;
      rst_n     = 1'b0;
      for (int i = 0; i < 256; i++) approx_tbl[i] = 8'h00;

      vecs[0] = '{0, 0,   0,     0,   0};
      vecs[1] = '{1, 225, 14400, 225, 57600};
      vecs[2] = '{2, 1,   1,     1,   17};

      repeat (3) @(negedge clk);
      chk("rst_busy",  32'(bus.busy), 32'd0);
      chk("rst_done",  32'(bus.done), 32'd0);
      chk("rst_ops",   32'({bus.a_op, bus.b_op}), 32'd0);
      chk("rst_stats", 32'(|{bus.err_count, bus.sum_err_dist,
                             bus.max_err_dist, bus.sum_rel_err}), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_no_start", 32'(bus.busy), 32'd0);

      // Table-driven sweeps
      for (int i = 0; i < 3; i++) begin
         mode = vecs[i].mode;
         run_sweep(0, (i == 0), cyc);
         chk($sformatf("vec%0d_busy_cycles", i), 32'(cyc), 32'(SWEEP_CYCLES));
         check_results($sformatf("vec%0d", i), vecs[i]);
         if (i == 0) begin
            repeat (10) @(negedge clk);
            chk("done_hold", 32'({bus.done, bus.busy}), 32'b10);
            check_results("vec0_held", vecs[0]);
         end
      end

      // start re-pulsed at busy cycle 100 is ignored
      mode = 1;
      run_sweep(100, 1'b0, cyc);
      chk("repulse_busy_cycles", 32'(cyc), 32'(SWEEP_CYCLES));
      check_results("repulse", vecs[1]);

      // Randomized multipliers against the reference model
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 3) == 0)
               approx_tbl[i] = 8'((i / 16) * (i % 16));
            else
               approx_tbl[i] = 8'($urandom_range(0, 255));
         end
         mode = 3;
         e = model(3);
         run_sweep(0, 1'b0, cyc);
         chk($sformatf("rnd%0d_busy_cycles", r), 32'(cyc), 32'(SWEEP_CYCLES));
         check_results($sformatf("rnd%0d", r), e);
      end

      // Reset pulse while pair 18 (1,2) is in its divide
      mode = 1;
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      for (int n = 1; n < 80; n++) @(negedge clk);
      chk("pre_reset_busy", 32'(bus.busy), 32'd1);
      chk("pre_reset_err",  32'(bus.err_count), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_status", 32'({bus.busy, bus.done}), 32'd0);
      chk("mid_rst_ops",    32'({bus.a_op, bus.b_op}), 32'd0);
      chk("mid_rst_stats",  32'(|{bus.err_count, bus.sum_err_dist,
                                  bus.max_err_dist, bus.sum_rel_err}), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_rst_idle", 32'({bus.busy, bus.done}), 32'd0);
      mode = 0;
      run_sweep(0, 1'b0, cyc);
      chk("post_rst_busy_cycles", 32'(cyc), 32'(SWEEP_CYCLES));
      check_results("post_rst", vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
